// File: rtl/ps2_key_decoder.sv
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : Set-2 scan-code decoder producing held-direction flags and a
//            latched last-key code with a one-cycle new-key strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_WIDTH      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic [3:0] dir_held,
    output logic [7:0] key_code,
    output logic       key_strobe,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]           C_EXT_PREFIX = 8'hE0;
    localparam logic [7:0]           C_BRK_PREFIX = 8'hF0;
    localparam logic [CNT_WIDTH-1:0] C_TIMER_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               r_state,    w_state_nx;
    logic [3:0]           r_arrow,    w_arrow_nx;
    logic [3:0]           r_wasd,     w_wasd_nx;
    logic [7:0]           r_key_code, w_key_code_nx;
    logic                 r_released, w_released_nx;
    logic                 r_strobe,   w_strobe_nx;
    logic [CNT_WIDTH-1:0] r_timer,    w_timer_nx;

    logic [3:0]           w_arrow_hit;
    logic [3:0]           w_wasd_hit;
    logic                 w_ignored;

    // Bit order [3]=left [2]=right [1]=up [0]=down for both key groups
    always_comb begin
        w_arrow_hit = 4'b0000;
        w_wasd_hit  = 4'b0000;
        w_ignored   = 1'b0;
        case (rx_data)
            8'h6B:   w_arrow_hit = 4'b1000;
            8'h74:   w_arrow_hit = 4'b0100;
            8'h75:   w_arrow_hit = 4'b0010;
            8'h72:   w_arrow_hit = 4'b0001;
            8'h1C:   w_wasd_hit  = 4'b1000;
            8'h23:   w_wasd_hit  = 4'b0100;
            8'h1D:   w_wasd_hit  = 4'b0010;
            8'h1B:   w_wasd_hit  = 4'b0001;
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF, 8'hE1:
                     w_ignored   = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nx    = r_state;
        w_arrow_nx    = r_arrow;
        w_wasd_nx     = r_wasd;
        w_key_code_nx = r_key_code;
        w_released_nx = r_released;
        w_strobe_nx   = 1'b0;
        w_timer_nx    = r_timer;

        if (rx_err) begin
            w_state_nx    = ST_IDLE;
            w_arrow_nx    = 4'b0000;
            w_wasd_nx     = 4'b0000;
            w_released_nx = 1'b1;
            w_timer_nx    = '0;
        end else if (rx_valid) begin
            w_timer_nx = '0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == C_EXT_PREFIX) begin
                        w_state_nx = ST_EXT;
                    end else if (rx_data == C_BRK_PREFIX) begin
                        w_state_nx = ST_BRK;
                    end else if (!w_ignored) begin
                        w_wasd_nx = r_wasd | w_wasd_hit;
                        // Same code while still held is typematic repeat
                        if (rx_data != r_key_code || r_released) begin
                            w_key_code_nx = rx_data;
                            w_strobe_nx   = 1'b1;
                            w_released_nx = 1'b0;
                        end
                    end
                end
                ST_EXT: begin
                    if (rx_data == C_BRK_PREFIX) begin
                        w_state_nx = ST_EXT_BRK;
                    end else if (rx_data != C_EXT_PREFIX) begin
                        w_arrow_nx = r_arrow | w_arrow_hit;
                        w_state_nx = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_wasd_nx = r_wasd & ~w_wasd_hit;
                    if (rx_data == r_key_code) begin
                        w_released_nx = 1'b1;
                    end
                    w_state_nx = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    w_arrow_nx = r_arrow & ~w_arrow_hit;
                    w_state_nx = ST_IDLE;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end else if (r_state == ST_IDLE) begin
            w_timer_nx = '0;
        end else if (r_timer == C_TIMER_LAST) begin
            w_state_nx = ST_IDLE;
            w_timer_nx = '0;
        end else begin
            w_timer_nx = r_timer + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_arrow    <= 4'b0000;
            r_wasd     <= 4'b0000;
            r_key_code <= 8'h00;
            r_released <= 1'b1;
            r_strobe   <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_arrow    <= w_arrow_nx;
            r_wasd     <= w_wasd_nx;
            r_key_code <= w_key_code_nx;
            r_released <= w_released_nx;
            r_strobe   <= w_strobe_nx;
            r_timer    <= w_timer_nx;
        end
    end

    assign dir_held   = r_arrow | r_wasd;
    assign key_code   = r_key_code;
    assign key_strobe = r_strobe;
    assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire
